// File: rtl/kugelblitz_axil_cfg_master.sv
// AXI-Lite initiator for the Kugelblitz port config slave, one transaction in flight; optional watchdog under KG_AXIL_TIMEOUT_EN.
// Latency: cmd accept -> AXI valid +1 cycle -> slave reply -> rsp_valid +1 cycle (3 cycles min with a zero-wait slave).
// Backpressure: cmd_ready only in IDLE; rsp_* held stable until rsp_ready; AXI valids held until their ready.
module kugelblitz_axil_cfg_master #(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       kg_clk,
  input  logic                       kg_rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AXIL_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AXIL_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [AXIL_STRB_WIDTH-1:0] cmd_wstrb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_write,
  output logic [AXIL_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                 rsp_resp,
  output logic                       busy,
  output logic [AXIL_ADDR_WIDTH-1:0] kg_m_axil_awaddr,
  output logic [2:0]                 kg_m_axil_awprot,
  output logic                       kg_m_axil_awvalid,
  input  logic                       kg_m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0] kg_m_axil_wdata,
  output logic [AXIL_STRB_WIDTH-1:0] kg_m_axil_wstrb,
  output logic                       kg_m_axil_wvalid,
  input  logic                       kg_m_axil_wready,
  input  logic [1:0]                 kg_m_axil_bresp,
  input  logic                       kg_m_axil_bvalid,
  output logic                       kg_m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0] kg_m_axil_araddr,
  output logic [2:0]                 kg_m_axil_arprot,
  output logic                       kg_m_axil_arvalid,
  input  logic                       kg_m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0] kg_m_axil_rdata,
  input  logic [1:0]                 kg_m_axil_rresp,
  input  logic                       kg_m_axil_rvalid,
  output logic                       kg_m_axil_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

  state_t state, state_nxt;
  logic   cmd_acc;
  logic   aw_done, w_done;
  logic   in_wait;
  logic   tmo;

  if (TIMEOUT_CYCLES < 2) begin : g_tmo_chk
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  assign cmd_acc = cmd_valid & cmd_ready;
  assign aw_done = ~kg_m_axil_awvalid | kg_m_axil_awready;
  assign w_done  = ~kg_m_axil_wvalid  | kg_m_axil_wready;
  assign in_wait = (state == WR_REQ) || (state == WR_RESP) ||
                   (state == RD_REQ) || (state == RD_DATA);

  assign rsp_valid        = (state == RESP);
  assign busy             = (state != IDLE);
  assign kg_m_axil_bready = (state == WR_RESP);
  assign kg_m_axil_rready = (state == RD_DATA);
  assign kg_m_axil_awprot = 3'b000;
  assign kg_m_axil_arprot = 3'b000;

`ifdef KG_AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt;

  assign tmo = in_wait && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge kg_clk or negedge kg_rst_n) begin
    if (!kg_rst_n) begin
      tmo_cnt <= '0;
    end else if (cmd_acc) begin
      tmo_cnt <= '0;
    end else if (in_wait) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Handshake completion is tested before the watchdog so a reply in the expiry cycle wins.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_acc) state_nxt = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done && w_done) state_nxt = WR_RESP;
               else if (tmo)          state_nxt = RESP;
      WR_RESP: if (kg_m_axil_bvalid || tmo) state_nxt = RESP;
      RD_REQ:  if (kg_m_axil_arready)  state_nxt = RD_DATA;
               else if (tmo)           state_nxt = RESP;
      RD_DATA: if (kg_m_axil_rvalid || tmo) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge kg_clk or negedge kg_rst_n) begin
    if (!kg_rst_n) begin
      state             <= IDLE;
      cmd_ready         <= 1'b0;
      kg_m_axil_awaddr  <= '0;
      kg_m_axil_awvalid <= 1'b0;
      kg_m_axil_wdata   <= '0;
      kg_m_axil_wstrb   <= '0;
      kg_m_axil_wvalid  <= 1'b0;
      kg_m_axil_araddr  <= '0;
      kg_m_axil_arvalid <= 1'b0;
      rsp_write         <= 1'b0;
      rsp_rdata         <= '0;
      rsp_resp          <= 2'b00;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);

      if (kg_m_axil_awvalid && kg_m_axil_awready) kg_m_axil_awvalid <= 1'b0;
      if (kg_m_axil_wvalid  && kg_m_axil_wready)  kg_m_axil_wvalid  <= 1'b0;
      if (kg_m_axil_arvalid && kg_m_axil_arready) kg_m_axil_arvalid <= 1'b0;
      // Reaching RESP with a valid still up only happens on watchdog expiry.
      if (state_nxt == RESP) begin
        kg_m_axil_awvalid <= 1'b0;
        kg_m_axil_wvalid  <= 1'b0;
        kg_m_axil_arvalid <= 1'b0;
      end

      if (cmd_acc) begin
        if (cmd_write) begin
          kg_m_axil_awaddr  <= cmd_addr;
          kg_m_axil_wdata   <= cmd_wdata;
          kg_m_axil_wstrb   <= cmd_wstrb;
          kg_m_axil_awvalid <= 1'b1;
          kg_m_axil_wvalid  <= 1'b1;
        end else begin
          kg_m_axil_araddr  <= cmd_addr;
          kg_m_axil_arvalid <= 1'b1;
        end
      end

      if (state == WR_RESP && kg_m_axil_bvalid) begin
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= kg_m_axil_bresp;
      end else if (state == RD_DATA && kg_m_axil_rvalid) begin
        rsp_write <= 1'b0;
        rsp_rdata <= kg_m_axil_rdata;
        rsp_resp  <= kg_m_axil_rresp;
      end else if (in_wait && state_nxt == RESP) begin
        rsp_write <= (state == WR_REQ) || (state == WR_RESP);
        rsp_rdata <= '0;
        rsp_resp  <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_kugelblitz_axil_cfg_master.sv
// Directed bench for kugelblitz_axil_cfg_master: zero-wait, delayed, staggered, back-pressured,
// reset-abort and watchdog/no-watchdog cases with hand-computed expectations.
module tb_kugelblitz_axil_cfg_master;

  logic        kg_clk = 1'b0;
  logic        kg_rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

  int n_chk = 0;
  int n_err = 0;

  always #5 kg_clk = ~kg_clk;

`ifdef KG_AXIL_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  kugelblitz_axil_cfg_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .kg_clk(kg_clk), .kg_rst_n(kg_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .kg_m_axil_awaddr(awaddr), .kg_m_axil_awprot(awprot),
    .kg_m_axil_awvalid(awvalid), .kg_m_axil_awready(awready),
    .kg_m_axil_wdata(wdata), .kg_m_axil_wstrb(wstrb),
    .kg_m_axil_wvalid(wvalid), .kg_m_axil_wready(wready),
    .kg_m_axil_bresp(bresp), .kg_m_axil_bvalid(bvalid), .kg_m_axil_bready(bready),
    .kg_m_axil_araddr(araddr), .kg_m_axil_arprot(arprot),
    .kg_m_axil_arvalid(arvalid), .kg_m_axil_arready(arready),
    .kg_m_axil_rdata(rdata), .kg_m_axil_rresp(rresp),
    .kg_m_axil_rvalid(rvalid), .kg_m_axil_rready(rready)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge kg_clk);
    #1;
  endtask

  // Zero-wait write; the response is then held back for 'hold' cycles before rsp_ready.
  task automatic wr_zero(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] br, input int hold);
    check("wr_cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    awready = 1; wready = 1;
    tick();  // cycle 1
    cmd_valid = 0;
    check("wr_awvalid_c1", awvalid, 1);
    check("wr_wvalid_c1", wvalid, 1);
    check("wr_awaddr", awaddr, a);
    check("wr_wdata", wdata, d);
    check("wr_wstrb", wstrb, s);
    check("wr_awprot", awprot, 0);
    check("wr_bready_c1", bready, 0);
    check("wr_cmd_ready_busy", cmd_ready, 0);
    bvalid = 1; bresp = br;
    tick();  // cycle 2
    check("wr_awvalid_c2", awvalid, 0);
    check("wr_wvalid_c2", wvalid, 0);
    check("wr_bready_c2", bready, 1);
    check("wr_rsp_valid_c2", rsp_valid, 0);
    tick();  // cycle 3
    bvalid = 0; bresp = 0; awready = 0; wready = 0;
    check("wr_rsp_valid_c3", rsp_valid, 1);
    check("wr_rsp_write", rsp_write, 1);
    check("wr_rsp_resp", rsp_resp, br);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_bready_c3", bready, 0);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1;
      tick();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_resp", rsp_resp, br);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    check("wr_cmd_ready_at_rsp", cmd_ready, 0);
    tick();
    rsp_ready = 0;
    check("wr_rsp_valid_done", rsp_valid, 0);
    check("wr_cmd_ready_after", cmd_ready, 1);
    check("wr_busy_after", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    repeat (2) @(posedge kg_clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_awaddr", awaddr, 0);
    kg_rst_n = 1;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // stray slave replies in IDLE must not be acknowledged
    bvalid = 1; rvalid = 1;
    #1;
    check("stray_bready", bready, 0);
    check("stray_rready", rready, 0);
    bvalid = 0; rvalid = 0;
    tick();

    wr_zero(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 0);

    // read: arready after 3 wait cycles, rvalid two cycles after the AR handshake
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
    tick();  // cycle 1
    cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("rd_arvalid_wait", arvalid, 1);
      check("rd_araddr", araddr, 32'h20);
      check("rd_rready_wait", rready, 0);
      tick();
    end
    arready = 1;
    check("rd_arvalid_hs", arvalid, 1);
    tick();
    arready = 0;
    check("rd_arvalid_done", arvalid, 0);
    check("rd_rready_c5", rready, 1);
    tick();
    check("rd_rready_c6", rready, 1);
    tick();
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = 0;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    check("rd_rsp_write", rsp_write, 0);
    check("rd_rsp_resp", rsp_resp, 0);
    check("rd_rready_resp", rready, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("rd_done_cmd_ready", cmd_ready, 1);

    // staggered write: awready in cycle 1, wready in cycle 4
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h44; cmd_wdata = 32'hA5A5_0001; cmd_wstrb = 4'h3;
    tick();  // cycle 1
    cmd_valid = 0;
    awready = 1;
    tick();  // cycle 2
    awready = 0;
    check("stg_awvalid_c2", awvalid, 0);
    check("stg_wvalid_c2", wvalid, 1);
    check("stg_bready_c2", bready, 0);
    tick();  // cycle 3
    check("stg_wvalid_c3", wvalid, 1);
    check("stg_wdata_c3", wdata, 32'hA5A5_0001);
    check("stg_bready_c3", bready, 0);
    tick();  // cycle 4
    wready = 1;
    check("stg_wvalid_c4", wvalid, 1);
    tick();  // cycle 5
    wready = 0;
    check("stg_wvalid_c5", wvalid, 0);
    check("stg_bready_c5", bready, 1);
    bvalid = 1; bresp = 2'b01;
    tick();
    bvalid = 0; bresp = 0;
    check("stg_rsp_valid", rsp_valid, 1);
    check("stg_rsp_resp", rsp_resp, 2'b01);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    wr_zero(32'h80, 32'h0BAD_F00D, 4'h5, 2'b10, 5);

    // reset while waiting for read data
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30;
    tick();
    cmd_valid = 0;
    arready = 1;
    tick();
    arready = 0;
    check("rst_mid_rready_pre", rready, 1);
    kg_rst_n = 0;
    #1;
    check("rst_mid_rready", rready, 0);
    check("rst_mid_arvalid", arvalid, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_busy", busy, 0);
    tick();
    kg_rst_n = 1;
    tick();
    check("rst_mid_cmd_ready", cmd_ready, 1);
    wr_zero(32'h14, 32'hCAFE_1234, 4'hC, 2'b00, 0);

    // slave never accepts the read address
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h58;
    tick();  // cycle 1: arvalid first high
    cmd_valid = 0;
    check("hang_arvalid_c1", arvalid, 1);
`ifdef KG_AXIL_TIMEOUT_EN
    repeat (15) tick();  // cycle 16
    check("tmo_arvalid_c16", arvalid, 1);
    check("tmo_rsp_valid_c16", rsp_valid, 0);
    tick();  // cycle 17
    check("tmo_arvalid_c17", arvalid, 0);
    check("tmo_rsp_valid_c17", rsp_valid, 1);
    check("tmo_rsp_resp", rsp_resp, 2'b11);
    check("tmo_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("tmo_cmd_ready", cmd_ready, 1);
`else
    repeat (1000) tick();
    check("notmo_arvalid", arvalid, 1);
    check("notmo_busy", busy, 1);
    check("notmo_rsp_valid", rsp_valid, 0);
    check("notmo_cmd_ready", cmd_ready, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
